// File: rtl/pipe_exe_stage_if.sv
// Execute-stage signal bundle: ID/EX operands and controls, forwarding sources and stage results.
// The stage itself connects through the slave modport; the driving pipeline uses master.
interface pipe_exe_stage_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] ea;
  logic [WIDTH-1:0] eb;
  logic [WIDTH-1:0] eimm;
  logic [WIDTH-1:0] epc4;
  logic [4:0]       ealuc;
  logic             ealuimm;
  logic [1:0]       E_ADEPEND;
  logic [1:0]       E_BDEPEND;
  logic             ejal;
  logic             ewreg;
  logic             ewmem;
  logic [WIDTH-1:0] mfwd;
  logic [WIDTH-1:0] wfwd;
  logic [WIDTH-1:0] mload;
  logic [WIDTH-1:0] ealu;
  logic [WIDTH-1:0] estore;
  logic             xwreg;
  logic             xwmem;
  logic             estall;
  logic             md_busy;

  modport master (
    output ea, eb, eimm, epc4, ealuc, ealuimm, E_ADEPEND, E_BDEPEND,
           ejal, ewreg, ewmem, mfwd, wfwd, mload,
    input  ealu, estore, xwreg, xwmem, estall, md_busy
  );

  modport slave (
    input  ea, eb, eimm, epc4, ealuc, ealuimm, E_ADEPEND, E_BDEPEND,
           ejal, ewreg, ewmem, mfwd, wfwd, mload,
    output ealu, estore, xwreg, xwmem, estall, md_busy
  );
endinterface

// File: rtl/pipe_exe_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, JAL link address, and an iterative
// HI/LO multiply/divide unit that stalls dependent MD instructions while it is busy.
module pipe_exe_stage #(
  parameter int WIDTH     = 32,
  parameter int MD_CYCLES = 33
) (
  input logic             clk,
  input logic             clr,
  pipe_exe_stage_if.slave ex
);
  localparam int ITERS = MD_CYCLES - 1;

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_SUB   = 5'b00001;
  localparam logic [4:0] OP_AND   = 5'b00010;
  localparam logic [4:0] OP_OR    = 5'b00011;
  localparam logic [4:0] OP_XOR   = 5'b00100;
  localparam logic [4:0] OP_LUI   = 5'b00101;
  localparam logic [4:0] OP_SLL   = 5'b00110;
  localparam logic [4:0] OP_SRL   = 5'b00111;
  localparam logic [4:0] OP_SRA   = 5'b01000;
  localparam logic [4:0] OP_SLT   = 5'b01001;
  localparam logic [4:0] OP_SLTU  = 5'b01010;
  localparam logic [4:0] OP_MULT  = 5'b10000;
  localparam logic [4:0] OP_MULTU = 5'b10001;
  localparam logic [4:0] OP_DIV   = 5'b10010;
  localparam logic [4:0] OP_DIVU  = 5'b10011;
  localparam logic [4:0] OP_MFHI  = 5'b10100;
  localparam logic [4:0] OP_MFLO  = 5'b10101;
  localparam logic [4:0] OP_MTHI  = 5'b10110;
  localparam logic [4:0] OP_MTLO  = 5'b10111;

  typedef enum logic [1:0] {MD_IDLE, MD_ITER, MD_FIX} md_state_t;

  function automatic logic [WIDTH-1:0] fwd_sel(input logic [1:0] sel, input logic [WIDTH-1:0] r,
                                               input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] w,
                                               input logic [WIDTH-1:0] l);
    case (sel)
      2'b00:   return r;
      2'b01:   return m;
      2'b10:   return w;
      default: return l;
    endcase
  endfunction

  logic [WIDTH-1:0] fa, fb, opb, alu_res;
  logic [WIDTH-1:0] hi, lo;
  logic             md_class, md_start, md_busy, estall;

  md_state_t        md_state, md_next;
  logic [5:0]       md_cnt;
  logic [WIDTH-1:0] md_hi, md_lo, md_b;
  logic             md_is_div, md_neg_q, md_neg_r;

  assign fa  = fwd_sel(ex.E_ADEPEND, ex.ea, ex.mfwd, ex.wfwd, ex.mload);
  assign fb  = fwd_sel(ex.E_BDEPEND, ex.eb, ex.mfwd, ex.wfwd, ex.mload);
  assign opb = ex.ealuimm ? ex.eimm : fb;

  // Codes 10000..10111 are the whole HI/LO class.
  assign md_class = (ex.ealuc[4:3] == 2'b10);
  assign estall   = md_busy & md_class;
  assign md_start = ~estall & (ex.ealuc inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});

  always_comb begin
    // NOTE: default first so every path assigns alu_res and no latch is inferred.
    alu_res = '0;
    case (ex.ealuc)
      OP_ADD:  alu_res = fa + opb;
      OP_SUB:  alu_res = fa - opb;
      OP_AND:  alu_res = fa & opb;
      OP_OR:   alu_res = fa | opb;
      OP_XOR:  alu_res = fa ^ opb;
      OP_LUI:  alu_res = {opb[15:0], 16'h0};
      OP_SLL:  alu_res = opb << fa[4:0];
      OP_SRL:  alu_res = opb >> fa[4:0];
      OP_SRA:  alu_res = $signed(opb) >>> fa[4:0];
      OP_SLT:  alu_res = WIDTH'($signed(fa) < $signed(opb));
      OP_SLTU: alu_res = WIDTH'(fa < opb);
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      default: alu_res = '0;
    endcase
  end

  assign ex.ealu    = ex.ejal ? ex.epc4 + WIDTH'(4) : alu_res;
  assign ex.estore  = fb;
  assign ex.xwreg   = ex.ewreg & ~estall;
  assign ex.xwmem   = ex.ewmem & ~estall;
  assign ex.estall  = estall;
  assign ex.md_busy = md_busy;

  // Sign capture at start: magnitudes go into the iterator, signs into the fix-up flags.
  logic             op_signed, sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  assign op_signed = (ex.ealuc == OP_MULT) || (ex.ealuc == OP_DIV);
  assign sign_a    = op_signed & fa[WIDTH-1];
  assign sign_b    = op_signed & fb[WIDTH-1];
  assign mag_a     = sign_a ? -fa : fa;
  assign mag_b     = sign_b ? -fb : fb;

  always_ff @(posedge clk) begin
    if (clr) md_state <= MD_IDLE;
    else     md_state <= md_next;
  end

  always_comb begin
    md_next = md_state;
    case (md_state)
      MD_IDLE: if (md_start) md_next = MD_ITER;
      MD_ITER: if (md_cnt == 6'(ITERS - 1)) md_next = MD_FIX;
      MD_FIX:  md_next = MD_IDLE;
      default: md_next = MD_IDLE;
    endcase
  end

  always_comb md_busy = (md_state != MD_IDLE);

  // One radix-2 step: multiplier/dividend shifts through md_lo, partial result builds in md_hi.
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  assign mul_sum  = {1'b0, md_hi} + (md_lo[0] ? {1'b0, md_b} : '0);
  assign div_sh   = {md_hi, md_lo[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, md_b};

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (clr) begin
      md_cnt    <= '0;
      md_hi     <= '0;
      md_lo     <= '0;
      md_b      <= '0;
      md_is_div <= 1'b0;
      md_neg_q  <= 1'b0;
      md_neg_r  <= 1'b0;
    end else if (md_start) begin
      md_cnt    <= '0;
      md_hi     <= '0;
      md_lo     <= mag_a;
      md_b      <= mag_b;
      md_is_div <= ex.ealuc[1];
      // A zero divisor yields all-ones quotient regardless of sign.
      md_neg_q  <= (sign_a ^ sign_b) & ~(ex.ealuc[1] && fb == '0);
      md_neg_r  <= ex.ealuc[1] ? sign_a : (sign_a ^ sign_b);
    end else if (md_state == MD_ITER) begin
      md_cnt <= md_cnt + 6'd1;
      if (md_is_div) begin
        if (!div_diff[WIDTH]) begin
          md_hi <= div_diff[WIDTH-1:0];
          md_lo <= {md_lo[WIDTH-2:0], 1'b1};
        end else begin
          md_hi <= div_sh[WIDTH-1:0];
          md_lo <= {md_lo[WIDTH-2:0], 1'b0};
        end
      end else begin
        {md_hi, md_lo} <= {mul_sum, md_lo[WIDTH-1:1]};
      end
    end
  end

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod_fix = md_neg_q ? -{md_hi, md_lo} : {md_hi, md_lo};
  assign quo_fix  = md_neg_q ? -md_lo : md_lo;
  assign rem_fix  = md_neg_r ? -md_hi : md_hi;

  // MTHI/MTLO are in the MD class, so they never coincide with a completion.
  always_ff @(posedge clk) begin
    if (clr) begin
      hi <= '0;
      lo <= '0;
    end else if (md_state == MD_FIX) begin
      if (md_is_div) begin
        hi <= rem_fix;
        lo <= quo_fix;
      end else begin
        {hi, lo} <= prod_fix;
      end
    end else if (!estall && ex.ealuc == OP_MTHI) begin
      hi <= fa;
    end else if (!estall && ex.ealuc == OP_MTLO) begin
      lo <= fa;
    end
  end
endmodule

// File: tb/tb_pipe_exe_stage.sv
// Randomized bench for pipe_exe_stage: a behavioural HI/LO + latency model checked every cycle,
// plus directed literal expectations for forwarding, ALU, JAL, multiply/divide and reset.
module tb_pipe_exe_stage;
  localparam logic [4:0] OP_ADD  = 5'b00000, OP_SRA  = 5'b01000, OP_SLT  = 5'b01001;
  localparam logic [4:0] OP_SLTU = 5'b01010, OP_LUI  = 5'b00101;
  localparam logic [4:0] OP_MULT = 5'b10000, OP_MULTU = 5'b10001, OP_DIV = 5'b10010;
  localparam logic [4:0] OP_DIVU = 5'b10011, OP_MFHI = 5'b10100, OP_MFLO = 5'b10101;
  localparam logic [4:0] OP_MTHI = 5'b10110, OP_MTLO = 5'b10111;
  localparam int LATENCY = 33;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  pipe_exe_stage_if bus ();
  pipe_exe_stage dut (.clk(clk), .clr(clr), .ex(bus));

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
  int          m_left = 0;

  function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] r);
    case (s)
      2'd0:    return r;
      2'd1:    return bus.mfwd;
      2'd2:    return bus.wfwd;
      default: return bus.mload;
    endcase
  endfunction

  function automatic bit is_md(input logic [4:0] c);
    return c >= 5'd16 && c <= 5'd23;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [4:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    case (c)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a & b;
      5'd3:    return a | b;
      5'd4:    return a ^ b;
      5'd5:    return b << 16;
      5'd6:    return b << a[4:0];
      5'd7:    return b >> a[4:0];
      5'd8:    return 32'(int'(b) >>> a[4:0]);
      5'd9:    return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      5'd10:   return (a < b) ? 32'd1 : 32'd0;
      5'd20:   return m_hi;
      5'd21:   return m_lo;
      default: return 32'd0;
    endcase
  endfunction

  // Returns {HI, LO}.
  function automatic logic [63:0] md_ref(input logic [4:0] c, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    sa = longint'(int'(a));
    sb = longint'(int'(b));
    ua = 64'(a);
    ub = 64'(b);
    case (c)
      OP_MULT:  return 64'(sa * sb);
      OP_MULTU: return ua * ub;
      OP_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(int'(a) % int'(b)), 32'(int'(a) / int'(b))};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  always @(posedge clk) begin
    if (clr) begin
      m_hi <= '0;
      m_lo <= '0;
      m_left <= 0;
    end else begin
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi <= m_phi;
          m_lo <= m_plo;
        end
      end
      if (!(m_left > 0 && is_md(bus.ealuc))) begin
        case (bus.ealuc)
          OP_MTHI: m_hi <= pick(bus.E_ADEPEND, bus.ea);
          OP_MTLO: m_lo <= pick(bus.E_ADEPEND, bus.ea);
          OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
            m_left <= LATENCY;
            {m_phi, m_plo} <= md_ref(bus.ealuc, pick(bus.E_ADEPEND, bus.ea),
                                     pick(bus.E_BDEPEND, bus.eb));
          end
          default: ;
        endcase
      end
    end
  end

  // Single compare process: every negedge once the model is synchronised.
  logic [31:0] c_fa, c_fb, c_b, c_alu;
  logic        c_stall;
  always @(negedge clk) begin
    if (chk_en) begin
      c_fa    = pick(bus.E_ADEPEND, bus.ea);
      c_fb    = pick(bus.E_BDEPEND, bus.eb);
      c_b     = bus.ealuimm ? bus.eimm : c_fb;
      c_stall = (m_left > 0) && is_md(bus.ealuc);
      c_alu   = bus.ejal ? bus.epc4 + 32'd4 : alu_ref(bus.ealuc, c_fa, c_b);
      check("ealu", bus.ealu, c_alu);
      check("estore", bus.estore, c_fb);
      check("estall", 32'(bus.estall), 32'(c_stall));
      check("md_busy", 32'(bus.md_busy), 32'(m_left > 0));
      check("xwreg", 32'(bus.xwreg), 32'(bus.ewreg & ~c_stall));
      check("xwmem", 32'(bus.xwmem), 32'(bus.ewmem & ~c_stall));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    bus.ea = '0; bus.eb = '0; bus.eimm = '0; bus.epc4 = '0;
    bus.ealuc = OP_ADD; bus.ealuimm = 1'b0;
    bus.E_ADEPEND = 2'd0; bus.E_BDEPEND = 2'd0;
    bus.ejal = 1'b0; bus.ewreg = 1'b0; bus.ewmem = 1'b0;
  endtask

  task automatic issue_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    set_nop();
    bus.ealuc = op; bus.ea = a; bus.eb = b;
    tick();
    set_nop();
  endtask

  task automatic read_hilo(input string nm, input logic [31:0] eh, input logic [31:0] el);
    int n;
    n = 0;
    set_nop();
    bus.ealuc = OP_MFLO; bus.ewreg = 1'b1;
    #2;
    while (bus.estall && n < LATENCY + 8) begin
      tick();
      #2;
      n++;
    end
    check({nm, " stall bound"}, 32'(bus.estall), 32'h0);
    check({nm, " LO"}, bus.ealu, el);
    tick();
    bus.ealuc = OP_MFHI;
    #2;
    check({nm, " HI"}, bus.ealu, eh);
    tick();
    set_nop();
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 9))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3, 4:    return 32'($urandom_range(0, 40)) - 32'd20;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [4:0] rnd_code();
    int r;
    r = $urandom_range(0, 99);
    if (r < 60) return 5'($urandom_range(0, 10));
    if (r < 75) return 5'($urandom_range(20, 21));
    if (r < 83) return 5'($urandom_range(22, 23));
    if (r < 93) return 5'($urandom_range(16, 19));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    set_nop();
    bus.mfwd = '0; bus.wfwd = '0; bus.mload = '0;
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
    chk_en = 1'b1;
    #2;
    check("reset md_busy", 32'(bus.md_busy), 32'h0);
    check("reset estall", 32'(bus.estall), 32'h0);
    read_hilo("reset", 32'h0, 32'h0);

    // Forwarding sweep.
    bus.ea = 32'd1; bus.eb = 32'd2; bus.mfwd = 32'd5; bus.wfwd = 32'd7; bus.mload = 32'd9;
    bus.ealuc = OP_ADD;
    for (int s = 0; s < 4; s++) begin
      logic [31:0] exp_fwd [4];
      exp_fwd = '{32'd3, 32'd7, 32'd9, 32'd11};
      bus.E_ADEPEND = 2'(s);
      #2;
      check($sformatf("fwd A=%0d", s), bus.ealu, exp_fwd[s]);
      tick();
    end
    bus.E_ADEPEND = 2'd0; bus.E_BDEPEND = 2'd3;
    #2;
    check("fwd B estore", bus.estore, 32'd9);
    check("fwd B ealu", bus.ealu, 32'd10);
    tick();

    // ALU and JAL literals.
    set_nop();
    bus.ealuc = OP_SRA; bus.ea = 32'd4; bus.eb = 32'h8000_0000;
    #2; check("sra", bus.ealu, 32'hF800_0000); tick();
    bus.ealuc = OP_SLT; bus.ea = 32'hFFFF_FFFF; bus.eb = 32'd1;
    #2; check("slt", bus.ealu, 32'd1); tick();
    bus.ealuc = OP_SLTU;
    #2; check("sltu", bus.ealu, 32'd0); tick();
    bus.ealuc = OP_LUI; bus.ealuimm = 1'b1; bus.eimm = 32'h0000_1234; bus.eb = 32'hDEAD_BEEF;
    #2;
    check("lui", bus.ealu, 32'h1234_0000);
    check("lui estore", bus.estore, 32'hDEAD_BEEF);
    tick();
    set_nop();
    bus.ejal = 1'b1; bus.epc4 = 32'h400; bus.ealuc = OP_SUB_DUMMY();
    #2; check("jal", bus.ealu, 32'h404); tick();

    // MULT -3*7 with a dependent MFLO: 33 stalled cycles.
    issue_md(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    bus.ealuc = OP_MFLO; bus.ewreg = 1'b1;
    for (int i = 0; i < LATENCY; i++) begin
      #2;
      check($sformatf("mult stall c%0d", i), 32'(bus.estall), 32'h1);
      check($sformatf("mult xwreg c%0d", i), 32'(bus.xwreg), 32'h0);
      tick();
    end
    read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    // Independent ADD flows during a divide.
    issue_md(OP_DIVU, 32'd100, 32'd7);
    bus.ealuc = OP_ADD; bus.ea = 32'd10; bus.eb = 32'd20; bus.ewreg = 1'b1;
    #2;
    check("add busy estall", 32'(bus.estall), 32'h0);
    check("add busy xwreg", 32'(bus.xwreg), 32'h1);
    check("add busy ealu", bus.ealu, 32'd30);
    check("add busy md_busy", 32'(bus.md_busy), 32'h1);
    tick();
    read_hilo("divu", 32'd2, 32'd14);

    issue_md(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    read_hilo("div -7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue_md(OP_DIV, 32'd5, 32'd0);
    read_hilo("div 5/0", 32'd5, 32'hFFFF_FFFF);
    issue_md(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    read_hilo("div ovf", 32'h0, 32'h8000_0000);

    // Reset mid-operation, then a fresh multiply.
    issue_md(OP_MULT, 32'd12345, 32'd6789);
    repeat (9) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    #2;
    check("clr md_busy", 32'(bus.md_busy), 32'h0);
    read_hilo("after clr", 32'h0, 32'h0);
    issue_md(OP_MULT, 32'd6, 32'd7);
    read_hilo("mult 6*7", 32'h0, 32'd42);

    // Randomized traffic, checked every cycle by the compare process.
    for (int i = 0; i < 3000; i++) begin
      bus.ea = rnd_val(); bus.eb = rnd_val(); bus.eimm = rnd_val(); bus.epc4 = $urandom;
      bus.mfwd = rnd_val(); bus.wfwd = rnd_val(); bus.mload = rnd_val();
      bus.ealuc = rnd_code();
      bus.ealuimm = ($urandom_range(0, 3) == 0);
      bus.E_ADEPEND = 2'($urandom_range(0, 3));
      bus.E_BDEPEND = 2'($urandom_range(0, 3));
      bus.ejal = ($urandom_range(0, 15) == 0);
      bus.ewreg = 1'($urandom);
      bus.ewmem = 1'($urandom);
      clr = ($urandom_range(0, 599) == 0);
      tick();
    end
    clr = 1'b0;
    set_nop();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Any non-zero ALU code works for the JAL check; SUB makes the override visible.
  function automatic logic [4:0] OP_SUB_DUMMY();
    return 5'b00001;
  endfunction
endmodule
